// File: rtl/sram_responder.sv
// sram_responder: synchronous 16-bit SRAM-style slave with byte lanes.
// Optional access counters enabled by defining SRAM_ACCESS_COUNT_EN.
//
// Ports:
//   Clk, Reset          - clock, async active-high reset
//   CE, OE, WE          - chip/output/write enables (active low)
//   UB, LB              - upper/lower byte lane selects (active low)
//   ADDR[19:0]          - word address, low ADDR_BITS decoded
//   Data[15:0]          - bidirectional bus, driven only while reading
//   RdCount, WrCount    - completed reads / committed writes (optional)
module sram_responder #(
    parameter int ADDR_BITS = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        OE,
    input  logic        WE,
    input  logic        UB,
    input  logic        LB,
    input  logic [19:0] ADDR,
    inout  wire  [15:0] Data
`ifdef SRAM_ACCESS_COUNT_EN
    ,
    output logic [15:0] RdCount,
    output logic [15:0] WrCount
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] pend_addr_q, pend_addr_d;
    logic [15:0]          pend_data_q, pend_data_d;
    logic                 pend_ub_q, pend_ub_d;
    logic                 pend_lb_q, pend_lb_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [15:0]          rd_data_q, rd_data_d;

    logic [15:0]          mem_q [2**ADDR_BITS];

    logic [ADDR_BITS-1:0] addr;
    logic                 wr_req;
    logic                 rd_req;
    logic                 capture;
    logic                 commit;
    logic                 rd_done;
    logic                 drive;

    // Upper address bits alias; kept only to show they are intentionally unused.
    logic                 unused_addr;
    assign unused_addr = ^ADDR[19:ADDR_BITS];

    assign addr   = ADDR[ADDR_BITS-1:0];
    assign wr_req = !CE && !WE;
    assign rd_req = !CE && WE && !OE;

    // Bus is driven from the registered word but gated by the live pins,
    // so releasing CE/OE or dropping WE tristates without waiting a clock.
    assign drive = (state_q == READ) && rd_req;
    assign Data  = drive ? rd_data_q : 16'hzzzz;

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        pend_ub_d   = pend_ub_q;
        pend_lb_d   = pend_lb_q;
        pend_vld_d  = pend_vld_q;
        rd_data_d   = rd_data_q;
        capture     = 1'b0;
        commit      = 1'b0;
        rd_done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d = WRITE;
                    capture = 1'b1;
                end else if (rd_req) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (!rd_req) begin
                    rd_done = 1'b1;
                    if (wr_req) begin
                        state_d = WRITE;
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                if (wr_req) begin
                    capture = 1'b1;
                end else begin
                    commit     = pend_vld_q;
                    pend_vld_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            pend_addr_d = addr;
            pend_data_d = Data;
            pend_ub_d   = UB;
            pend_lb_d   = LB;
            pend_vld_d  = 1'b1;
        end

        // Any commit lands on an earlier edge than the next READ entry,
        // so the array never returns stale data and needs no bypass.
        if (state_d == READ) begin
            rd_data_d[15:8] = UB ? 8'h00 : mem_q[addr][15:8];
            rd_data_d[7:0]  = LB ? 8'h00 : mem_q[addr][7:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            pend_ub_q   <= 1'b1;
            pend_lb_q   <= 1'b1;
            pend_vld_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            pend_ub_q   <= pend_ub_d;
            pend_lb_q   <= pend_lb_d;
            pend_vld_q  <= pend_vld_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge Clk) begin
        if (commit) begin
            if (!pend_ub_q) mem_q[pend_addr_q][15:8] <= pend_data_q[15:8];
            if (!pend_lb_q) mem_q[pend_addr_q][7:0]  <= pend_data_q[7:0];
        end
    end

`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q + {15'd0, rd_done};
        wr_cnt_d = wr_cnt_q + {15'd0, commit};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign RdCount = rd_cnt_q;
    assign WrCount = wr_cnt_q;
`else
    logic unused_rd_done;
    assign unused_rd_done = rd_done;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed bench for sram_responder.
// Counter checks compile in when SRAM_ACCESS_COUNT_EN is defined.
module tb_sram_responder;

    logic        Clk;
    logic        Reset;
    logic        CE, OE, WE, UB, LB;
    logic [19:0] ADDR;
    wire  [15:0] Data;
    logic [15:0] tb_drv;
    logic        tb_en;
    logic [15:0] q;
    int          checks;
    int          errors;
`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] RdCount, WrCount;
`endif

    assign Data = tb_en ? tb_drv : 16'hzzzz;

    sram_responder #(.ADDR_BITS(10)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .CE     (CE),
        .OE     (OE),
        .WE     (WE),
        .UB     (UB),
        .LB     (LB),
        .ADDR   (ADDR),
        .Data   (Data)
`ifdef SRAM_ACCESS_COUNT_EN
        ,
        .RdCount(RdCount),
        .WrCount(WrCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bench drives zero; any DUT drive of a non-zero word shows up.
    task automatic check_released(input string tag);
        tb_drv = 16'h0000;
        tb_en  = 1'b1;
        #1;
        check(tag, Data, 16'h0000);
        tb_en  = 1'b0;
    endtask

    task automatic sram_write(input logic [19:0] a, input logic [15:0] d,
                              input logic ub, input logic lb);
        ADDR = a; UB = ub; LB = lb;
        tb_drv = d; tb_en = 1'b1;
        CE = 1'b0; WE = 1'b0; OE = 1'b1;
        tick();
        tick();
        WE = 1'b1; CE = 1'b1; tb_en = 1'b0;
        tick();
    endtask

    task automatic sram_read(input logic [19:0] a, input logic ub,
                             input logic lb, output logic [15:0] d);
        ADDR = a; UB = ub; LB = lb;
        CE = 1'b0; WE = 1'b1; OE = 1'b0;
        tick();
        d = Data;
        CE = 1'b1; OE = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b1;
        CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b0; LB = 1'b0;
        ADDR = '0; tb_drv = '0; tb_en = 1'b0;
        tick();
        tick();
        check_released("reset_release");
        Reset = 1'b0;
        tick();

        // Basic write then read
        sram_write(20'h00005, 16'h1234, 1'b0, 1'b0);
        sram_read(20'h00005, 1'b0, 1'b0, q);
        check("wr_rd_basic", q, 16'h1234);

        // Overwrite, read immediately after commit
        sram_write(20'h00005, 16'h9999, 1'b0, 1'b0);
        sram_read(20'h00005, 1'b0, 1'b0, q);
        check("no_stale", q, 16'h9999);

        // Address change while staying in READ, then immediate release
        sram_write(20'h00008, 16'hC0DE, 1'b0, 1'b0);
        ADDR = 20'h00005; UB = 1'b0; LB = 1'b0;
        CE = 1'b0; WE = 1'b1; OE = 1'b0;
        tick();
        check("rd_first", Data, 16'h9999);
        ADDR = 20'h00008;
        tick();
        check("rd_addr_chg", Data, 16'hC0DE);
        OE = 1'b1;
        check_released("oe_release");
        CE = 1'b1;
        tick();

        // Byte lanes
        sram_write(20'h00010, 16'hABCD, 1'b0, 1'b0);
        sram_write(20'h00010, 16'h5566, 1'b1, 1'b0);
        sram_read(20'h00010, 1'b0, 1'b0, q);
        check("lane_wr_lo", q, 16'hAB66);
        sram_read(20'h00010, 1'b0, 1'b1, q);
        check("lane_rd_hi", q, 16'hAB00);

        // Aliasing
        sram_write(20'h00400, 16'hBEEF, 1'b0, 1'b0);
        sram_read(20'h00000, 1'b0, 1'b0, q);
        check("alias", q, 16'hBEEF);

        // No lanes selected: nothing written, nothing read
        sram_write(20'h00000, 16'h1111, 1'b1, 1'b1);
        sram_read(20'h00000, 1'b0, 1'b0, q);
        check("wr_no_lane", q, 16'hBEEF);
        sram_read(20'h00000, 1'b1, 1'b1, q);
        check("rd_no_lane", q, 16'h0000);

        // Last capture wins (address, data and lanes)
        sram_write(20'h00020, 16'h3333, 1'b0, 1'b0);
        sram_write(20'h00021, 16'hAAAA, 1'b0, 1'b0);
        CE = 1'b0; WE = 1'b0; OE = 1'b1; UB = 1'b0; LB = 1'b0;
        ADDR = 20'h00020; tb_drv = 16'h1111; tb_en = 1'b1;
        tick();
        ADDR = 20'h00021; tb_drv = 16'h2222; UB = 1'b1;
        tick();
        WE = 1'b1; CE = 1'b1; tb_en = 1'b0; UB = 1'b0;
        tick();
        sram_read(20'h00021, 1'b0, 1'b0, q);
        check("last_cap_new", q, 16'hAA22);
        sram_read(20'h00020, 1'b0, 1'b0, q);
        check("last_cap_old", q, 16'h3333);

        // Reset mid-write discards the pending write
        sram_write(20'h00007, 16'h0001, 1'b0, 1'b0);
        ADDR = 20'h00007; UB = 1'b0; LB = 1'b0;
        CE = 1'b0; WE = 1'b0; OE = 1'b1;
        tb_drv = 16'hFFFF; tb_en = 1'b1;
        tick();
        tick();
        Reset = 1'b1;
        #1;
        check("rst_bus", Data, 16'hFFFF);
        WE = 1'b1; CE = 1'b1; tb_en = 1'b0;
        check_released("rst_z");
        tick();
        Reset = 1'b0;
        tick();
        sram_read(20'h00007, 1'b0, 1'b0, q);
        check("rst_discard", q, 16'h0001);

        // All enables low: write wins, bus never driven by the block
        sram_read(20'h00010, 1'b0, 1'b0, q);
        check("pre_wroe", q, 16'hAB66);
        ADDR = 20'h00030; UB = 1'b0; LB = 1'b0;
        tb_drv = 16'h0F0F; tb_en = 1'b1;
        CE = 1'b0; WE = 1'b0; OE = 1'b0;
        #1;
        check("wroe_idle", Data, 16'h0F0F);
        tick();
        check("wroe_wr1", Data, 16'h0F0F);
        tick();
        check("wroe_wr2", Data, 16'h0F0F);
        WE = 1'b1; CE = 1'b1; OE = 1'b1; tb_en = 1'b0;
        tick();
        sram_read(20'h00030, 1'b0, 1'b0, q);
        check("wroe_commit", q, 16'h0F0F);

`ifdef SRAM_ACCESS_COUNT_EN
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        check("cnt_rst_rd", RdCount, 16'd0);
        check("cnt_rst_wr", WrCount, 16'd0);
        sram_write(20'h00040, 16'h0040, 1'b0, 1'b0);
        sram_write(20'h00041, 16'h0041, 1'b0, 1'b0);
        sram_write(20'h00042, 16'h0042, 1'b1, 1'b1);
        sram_read(20'h00040, 1'b0, 1'b0, q);
        sram_read(20'h00041, 1'b0, 1'b0, q);
        check("cnt_rd", RdCount, 16'd2);
        check("cnt_wr", WrCount, 16'd3);
        Reset = 1'b1;
        #1;
        check("cnt_clr_rd", RdCount, 16'd0);
        check("cnt_clr_wr", WrCount, 16'd0);
        tick();
        Reset = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
